// File: rtl/ysyx_24110006_pkg.sv
// rtl/ysyx_24110006_pkg.sv - shared types and constants for the instruction fetch unit
// Contents: ifu_state_t (IDLE/WAIT/DROP), IFU_RESET_PC, INST_W.
package ysyx_24110006_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,   // no request outstanding
        IFU_WAIT = 2'd1,   // one request outstanding, result will be queued
        IFU_DROP = 2'd2    // one request outstanding, result will be discarded
    } ifu_state_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h3000_0000;
    localparam int          INST_W       = 32;

endpackage

// File: rtl/ysyx_24110006_inst_queue.sv
// rtl/ysyx_24110006_inst_queue.sv - circular instruction queue holding {pc, inst} pairs
// Ports: clk/rst_n (async active-low); push/push_pc/push_inst write an entry;
//        pop removes the head when non-empty; flush empties the queue (wins over push/pop);
//        valid/head_pc/head_inst present the head (zero while empty); count is the occupancy.
module ysyx_24110006_inst_queue
    import ysyx_24110006_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [31:0]              push_pc,
    input  logic [INST_W-1:0]        push_inst,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     valid,
    output logic [31:0]              head_pc,
    output logic [INST_W-1:0]        head_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [31:0]       pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    // The fetch credit scheme means a push never meets a full queue, so push is not gated on count.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    // Storage is not reset, so the head is forced to zero while empty.
    assign valid     = (count != '0);
    assign head_pc   = valid ? pc_mem[rd_ptr]   : '0;
    assign head_inst = valid ? inst_mem[rd_ptr] : '0;

endmodule

// File: rtl/ysyx_24110006_ifu.sv
// rtl/ysyx_24110006_ifu.sv - instruction fetch unit: PC owner, icache requester, decode queue
// Ports: i_clock, i_reset_n (async active-low);
//        o_icache_valid/o_icache_pc: one-cycle fetch request and its address;
//        i_icache_valid/i_icache_inst: one-cycle response;
//        i_redirect_valid/i_redirect_pc: control-flow redirect from execute;
//        o_idu_valid/o_idu_inst/o_idu_pc/i_idu_ready: queue head handshake to decode.
module ysyx_24110006_ifu
    import ysyx_24110006_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = IFU_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    output logic              o_icache_valid,
    output logic [31:0]       o_icache_pc,
    input  logic              i_icache_valid,
    input  logic [INST_W-1:0] i_icache_inst,
    input  logic              i_redirect_valid,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_idu_valid,
    output logic [INST_W-1:0] o_idu_inst,
    output logic [31:0]       o_idu_pc,
    input  logic              i_idu_ready
);

    ifu_state_t                   state;
    ifu_state_t                   next_state;
    logic [31:0]                  pc;
    logic [31:0]                  next_pc;
    logic                         icache_req_q;
    logic                         issue;
    logic                         push;
    logic                         flush;
    logic                         outstanding;
    logic                         credit;
    logic [31:0]                  occupancy;
    logic [31:0]                  redirect_target;
    logic [$clog2(QUEUE_DEPTH):0] q_count;
    logic                         unused_redirect_lsbs;

    // Targets are word aligned; the low two bits are dropped.
    assign redirect_target      = {i_redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    // Queued entries plus the in-flight one must leave room, so a returning
    // response always has a slot.
    assign outstanding = (state != IFU_IDLE);
    assign occupancy   = 32'(q_count) + 32'(outstanding);
    assign credit      = occupancy < 32'(QUEUE_DEPTH);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IFU_IDLE;
            pc           <= RESET_PC;
            icache_req_q <= 1'b0;
        end else begin
            state        <= next_state;
            pc           <= next_pc;
            icache_req_q <= issue;
        end
    end

    always_comb begin
        next_state = state;
        next_pc    = pc;
        issue      = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            IFU_IDLE: begin
                // A response seen here is stale and deliberately ignored.
                if (i_redirect_valid) begin
                    next_pc = redirect_target;
                    flush   = 1'b1;
                end else if (credit) begin
                    issue      = 1'b1;
                    next_state = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (i_redirect_valid) begin
                    next_pc    = redirect_target;
                    flush      = 1'b1;
                    // A response in the same cycle belongs to the old path and closes the request.
                    next_state = i_icache_valid ? IFU_IDLE : IFU_DROP;
                end else if (i_icache_valid) begin
                    push       = 1'b1;
                    next_pc    = pc + 32'd4;
                    next_state = IFU_IDLE;
                end
            end
            IFU_DROP: begin
                if (i_redirect_valid) begin
                    next_pc = redirect_target;
                    flush   = 1'b1;
                end
                if (i_icache_valid) begin
                    next_state = IFU_IDLE;
                end
            end
            default: begin
                next_state = IFU_IDLE;
            end
        endcase
    end

    assign o_icache_valid = icache_req_q;
    assign o_icache_pc    = pc;

    ysyx_24110006_inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (i_clock),
        .rst_n     (i_reset_n),
        .push      (push),
        .push_pc   (pc),
        .push_inst (i_icache_inst),
        .pop       (i_idu_ready),
        .flush     (flush),
        .valid     (o_idu_valid),
        .head_pc   (o_idu_pc),
        .head_inst (o_idu_inst),
        .count     (q_count)
    );

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// tb/tb_ysyx_24110006_ifu.sv - randomized self-checking bench for ysyx_24110006_ifu
module tb_ysyx_24110006_ifu;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        i_clock;
    logic        i_reset_n;
    logic        o_icache_valid;
    logic [31:0] o_icache_pc;
    logic        i_icache_valid;
    logic [31:0] i_icache_inst;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_idu_valid;
    logic [31:0] o_idu_inst;
    logic [31:0] o_idu_pc;
    logic        i_idu_ready;

    ysyx_24110006_ifu #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .i_clock          (i_clock),
        .i_reset_n        (i_reset_n),
        .o_icache_valid   (o_icache_valid),
        .o_icache_pc      (o_icache_pc),
        .i_icache_valid   (i_icache_valid),
        .i_icache_inst    (i_icache_inst),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_idu_valid      (o_idu_valid),
        .o_idu_inst       (o_idu_inst),
        .o_idu_pc         (o_idu_pc),
        .i_idu_ready      (i_idu_ready)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference: queue contents as decode should see them, next fetch address,
    // and whether a request is in flight and whether its answer is wanted.
    ent_t        mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_discard;
    bit          exp_pulse;
    logic [31:0] exp_pc;

    int          total = 0;
    int          bad   = 0;
    int          cur   = 0;
    int          resp_due = -1;
    int          lat   = 3;
    bit          saw_pulse;
    logic [31:0] pulse_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cur);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        acc_log.delete();
        m_pc      = RST_PC;
        m_busy    = 1'b0;
        m_discard = 1'b0;
        exp_pulse = 1'b0;
    endtask

    task automatic model_edge();
        int   pre;
        ent_t e;
        pre       = mq.size();
        exp_pulse = 1'b0;
        if (pre > 0 && i_idu_ready) begin
            acc_log.push_back(mq[0].pc);
            void'(mq.pop_front());
        end
        if (i_redirect_valid) begin
            m_pc = {i_redirect_pc[31:2], 2'b00};
            mq.delete();
            if (m_busy) begin
                if (i_icache_valid) m_busy = 1'b0;
                else                m_discard = 1'b1;
            end
        end else if (m_busy) begin
            if (i_icache_valid) begin
                if (!m_discard) begin
                    e.pc   = m_pc;
                    e.inst = i_icache_inst;
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
                m_busy    = 1'b0;
                m_discard = 1'b0;
            end
        end else if (pre < DEPTH) begin
            exp_pulse = 1'b1;
            exp_pc    = m_pc;
            m_busy    = 1'b1;
            m_discard = 1'b0;
        end
    endtask

    task automatic check_outputs();
        if (!i_reset_n) begin
            chk("rst_icache_valid", o_icache_valid, 0);
            chk("rst_icache_pc", o_icache_pc, RST_PC);
            chk("rst_idu_valid", o_idu_valid, 0);
            chk("rst_idu_pc", o_idu_pc, 0);
            chk("rst_idu_inst", o_idu_inst, 0);
        end else begin
            chk("icache_valid", o_icache_valid, exp_pulse);
            if (exp_pulse) chk("icache_pc", o_icache_pc, exp_pc);
            chk("idu_valid", o_idu_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("idu_pc", o_idu_pc, mq[0].pc);
                chk("idu_inst", o_idu_inst, mq[0].inst);
            end
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        if (i_reset_n) model_edge();
        else           exp_pulse = 1'b0;
        #1;
        cur++;
        check_outputs();
        saw_pulse = o_icache_valid;
        if (o_icache_valid) begin
            pulse_pc = o_icache_pc;
            resp_due = cur + lat;
        end
        i_icache_valid   = (cur == resp_due);
        i_icache_inst    = $urandom;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = $urandom;
    endtask

    task automatic wait_pulse(input string nm, output logic [31:0] pc);
        bit got;
        got = 1'b0;
        pc  = 32'hdead_beef;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (saw_pulse) begin
                got = 1'b1;
                pc  = pulse_pc;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: no request pulse within 60 cycles", nm);
        end
    endtask

    // Called right after an edge; reset asserts asynchronously mid-cycle.
    task automatic do_reset();
        i_reset_n        = 1'b0;
        i_icache_valid   = 1'b0;
        i_redirect_valid = 1'b0;
        resp_due         = -1;
        model_reset();
        #1;
        check_outputs();
        step();
        step();
        i_reset_n = 1'b1;
    endtask

    logic [31:0] p;
    int          npulse;

    initial begin
        i_reset_n        = 1'b1;
        i_icache_valid   = 1'b0;
        i_icache_inst    = '0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_idu_ready      = 1'b1;
        model_reset();
        @(posedge i_clock);
        #1;

        // Streaming fetch with decode always ready.
        lat = 3;
        do_reset();
        wait_pulse("t1_p0", p); chk("t1_req0", p, 32'h3000_0000);
        wait_pulse("t1_p1", p); chk("t1_req1", p, 32'h3000_0004);
        wait_pulse("t1_p2", p); chk("t1_req2", p, 32'h3000_0008);
        for (int i = 0; i < 10; i++) step();
        chk("t1_log_n", acc_log.size() >= 3, 1);
        if (acc_log.size() >= 3) begin
            chk("t1_log0", acc_log[0], 32'h3000_0000);
            chk("t1_log1", acc_log[1], 32'h3000_0004);
            chk("t1_log2", acc_log[2], 32'h3000_0008);
        end

        // Decode stalled: queue fills to two, fetch stops, then resumes.
        i_idu_ready = 1'b0;
        do_reset();
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (saw_pulse) npulse++;
        end
        chk("t2_pulses", npulse, 2);
        chk("t2_head_valid", o_idu_valid, 1);
        chk("t2_head_pc", o_idu_pc, 32'h3000_0000);
        i_idu_ready = 1'b1;
        wait_pulse("t2_resume", p); chk("t2_resume_pc", p, 32'h3000_0008);
        chk("t2_log_n", acc_log.size() >= 2, 1);
        if (acc_log.size() >= 2) chk("t2_log1", acc_log[1], 32'h3000_0004);

        // Redirect during WAIT; its response is dropped.
        do_reset();
        wait_pulse("t3_p0", p);
        step();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h8000_0010;
        wait_pulse("t3_p1", p); chk("t3_req_pc", p, 32'h8000_0010);
        chk("t3_queue_empty", o_idu_valid, 0);
        chk("t3_nothing_decoded", acc_log.size(), 0);

        // Redirect coinciding with the response.
        step(); step(); step();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h8000_0020;
        wait_pulse("t4_p", p); chk("t4_req_pc", p, 32'h8000_0020);
        chk("t4_nothing_decoded", acc_log.size(), 0);

        // Misaligned target, then two redirects while dropping.
        step();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h8000_0003;
        wait_pulse("t5_p0", p); chk("t5_aligned_pc", p, 32'h8000_0000);
        step();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0100;
        step();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0200;
        wait_pulse("t5_p1", p); chk("t5_newest_pc", p, 32'h0000_0200);

        // Random traffic against the reference.
        npulse = 0;
        for (int i = 0; i < 1500; i++) begin
            i_idu_ready = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(1, 5);
            if ($urandom_range(0, 15) == 0) begin
                i_redirect_valid = 1'b1;
                i_redirect_pc    = $urandom;
            end
            step();
            if (saw_pulse) npulse++;
        end
        chk("rand_progress", npulse > 50, 1);

        // Reset while a request is outstanding; a late response must be ignored.
        i_idu_ready = 1'b1;
        lat = 3;
        wait_pulse("t7_p0", p);
        step();
        do_reset();
        i_icache_valid = 1'b1;
        i_icache_inst  = 32'h0bad_0bad;
        wait_pulse("t7_p1", p); chk("t7_req_pc", p, 32'h3000_0000);
        for (int i = 0; i < 8; i++) step();
        chk("t7_log_n", acc_log.size() >= 1, 1);
        if (acc_log.size() >= 1) chk("t7_log0", acc_log[0], 32'h3000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
